eth_tx_rr_arbiter: RTL

//  Shares the single 10G MAC TX AXI-Stream port (tx0_axis_*) between P_REQ_NUM requesters.

---
 rtl/eth_tx_rr_arbiter_if.sv | 33 +++
 rtl/eth_tx_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_rr_arbiter_if.sv
// AXI-Stream bundle between N requesters and the single 10G MAC TX port.
// master = arbiter side, slave = requesters plus MAC side.
interface eth_tx_rr_arbiter_if #(
    parameter int P_REQ_NUM = 4,
    parameter int P_DATA_W  = 64
);
    logic [P_REQ_NUM-1:0]            i_s_axis_tvalid;
    logic [P_REQ_NUM*P_DATA_W-1:0]   i_s_axis_tdata;
    logic [P_REQ_NUM*P_DATA_W/8-1:0] i_s_axis_tkeep;
    logic [P_REQ_NUM-1:0]            i_s_axis_tlast;
    logic [P_REQ_NUM-1:0]            i_s_axis_tuser;
    logic [P_REQ_NUM-1:0]            o_s_axis_tready;
    logic                            o_m_axis_tvalid;
    logic [P_DATA_W-1:0]             o_m_axis_tdata;
    logic [P_DATA_W/8-1:0]           o_m_axis_tkeep;
    logic                            o_m_axis_tlast;
    logic                            o_m_axis_tuser;
    logic                            i_m_axis_tready;

    modport master (
        input  i_s_axis_tvalid, i_s_axis_tdata, i_s_axis_tkeep, i_s_axis_tlast,
               i_s_axis_tuser, i_m_axis_tready,
        output o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tdata, o_m_axis_tkeep,
               o_m_axis_tlast, o_m_axis_tuser
    );

    modport slave (
        output i_s_axis_tvalid, i_s_axis_tdata, i_s_axis_tkeep, i_s_axis_tlast,
               i_s_axis_tuser, i_m_axis_tready,
        input  o_s_axis_tready, o_m_axis_tvalid, o_m_axis_tdata, o_m_axis_tkeep,
               o_m_axis_tlast, o_m_axis_tuser
    );
endinterface

// File: rtl/eth_tx_rr_arbiter.sv
// Per-packet round-robin arbiter in front of the 10G MAC TX AXI-Stream port.
// Define ARB_STALL_ABORT_EN to abort packets whose requester stalls mid-packet.
//
// state  | meaning
// IDLE   | no grant; pick next requester round-robin when link is up
// XFER   | granted requester passes straight through until its tlast is accepted
// ABORT  | stalled packet is closed with an error beat (macro only)
// DRAIN  | remaining beats of the aborted packet are swallowed (macro only)
module eth_tx_rr_arbiter #(
    parameter int P_REQ_NUM   = 4,
    parameter int P_DATA_W    = 64,
    parameter int P_STALL_CYC = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_link_up,
    eth_tx_rr_arbiter_if.master  axis,
    output logic [P_REQ_NUM-1:0] o_grant,
    output logic                 o_abort_pulse
);
    localparam int KEEP_W = P_DATA_W / 8;
    localparam int PTR_W  = $clog2(P_REQ_NUM);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(P_REQ_NUM - 1);

    if (P_REQ_NUM < 2 || P_REQ_NUM > 8 || P_STALL_CYC < 1 || P_STALL_CYC > 511) begin : g_param_check
        $error("eth_tx_rr_arbiter: parameter out of range");
    end

`ifdef ARB_STALL_ABORT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_ABORT = 2'd2, S_DRAIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1} state_t;
`endif

    state_t               state_q, state_d;
    logic [P_REQ_NUM-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     sel_idx;
    logic                 sel_found;
    logic                 cur_valid;
    logic                 cur_last;
    logic                 cur_beat;

`ifdef ARB_STALL_ABORT_EN
    logic [8:0] stall_q, stall_d;
    logic [9:0] stall_inc;
    logic       abort_pulse_q, abort_pulse_d;
`endif

    assign cur_valid = axis.i_s_axis_tvalid[ptr_q];
    assign cur_last  = axis.i_s_axis_tlast[ptr_q];
    assign cur_beat  = cur_valid & axis.i_m_axis_tready;

    // Round-robin search starts just after the last granted requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < P_REQ_NUM; i++) begin
            cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
            if (!sel_found && axis.i_s_axis_tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            ptr_q         <= PTR_LAST;
`ifdef ARB_STALL_ABORT_EN
            stall_q       <= '0;
            abort_pulse_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
`ifdef ARB_STALL_ABORT_EN
            stall_q       <= stall_d;
            abort_pulse_q <= abort_pulse_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef ARB_STALL_ABORT_EN
        stall_d       = stall_q;
        abort_pulse_d = 1'b0;
        stall_inc     = {1'b0, stall_q} + 10'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_link_up && sel_found) begin
                    state_d          = S_XFER;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    ptr_d            = sel_idx;
`ifdef ARB_STALL_ABORT_EN
                    stall_d          = '0;
`endif
                end
            end
            S_XFER: begin
                if (cur_beat && cur_last) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
`ifdef ARB_STALL_ABORT_EN
                if (cur_beat) begin
                    stall_d = '0;
                end else if (!cur_valid) begin
                    stall_d = (stall_q == '1) ? stall_q : stall_inc[8:0];
                    // Abort on the cycle the count reaches the limit, not one later.
                    if (stall_inc == 10'(P_STALL_CYC)) begin
                        state_d       = S_ABORT;
                        abort_pulse_d = 1'b1;
                    end
                end
`endif
            end
`ifdef ARB_STALL_ABORT_EN
            S_ABORT: begin
                if (axis.i_m_axis_tready) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cur_valid && cur_last) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        axis.o_s_axis_tready = '0;
        axis.o_m_axis_tvalid = 1'b0;
        axis.o_m_axis_tdata  = '0;
        axis.o_m_axis_tkeep  = '0;
        axis.o_m_axis_tlast  = 1'b0;
        axis.o_m_axis_tuser  = 1'b0;
        case (state_q)
            S_XFER: begin
                axis.o_m_axis_tvalid        = cur_valid;
                axis.o_m_axis_tdata         = axis.i_s_axis_tdata[ptr_q*P_DATA_W +: P_DATA_W];
                axis.o_m_axis_tkeep         = axis.i_s_axis_tkeep[ptr_q*KEEP_W +: KEEP_W];
                axis.o_m_axis_tlast         = cur_last;
                axis.o_m_axis_tuser         = axis.i_s_axis_tuser[ptr_q];
                axis.o_s_axis_tready[ptr_q] = axis.i_m_axis_tready;
            end
`ifdef ARB_STALL_ABORT_EN
            S_ABORT: begin
                axis.o_m_axis_tvalid = 1'b1;
                axis.o_m_axis_tkeep  = KEEP_W'(1);
                axis.o_m_axis_tlast  = 1'b1;
                axis.o_m_axis_tuser  = 1'b1;
            end
            S_DRAIN: begin
                axis.o_s_axis_tready[ptr_q] = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign o_grant = grant_q;
`ifdef ARB_STALL_ABORT_EN
    assign o_abort_pulse = abort_pulse_q;
`else
    assign o_abort_pulse = 1'b0;
`endif
endmodule
